mc_cu: RTL

Multi-cycle control unit: the successor to the single-cycle decoder, driving a shared-ALU, shared-memory multi-cycle MIPS datapath. Decodes the same 20-instruction set (op/func) and sequences each instruction through IF/ID/EXE/MEM/WB with a state register. Memory waits are handled by an optional ready handshake. Emits per-cycle datapath enables plus a retire pulse and an illegal-instruction pulse.

---
 rtl/mc_cu_if.sv | 39 +++
 rtl/mc_cu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mc_cu_if.sv
// mc_cu_if: control-unit <-> datapath bundle.
// master (control unit): takes IR fields op/func, ALU is_zero and memory
// mem_ready; drives the datapath enables/selects, state, retire and illegal.
// slave (datapath side): the mirror image.
interface mc_cu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       is_zero;
    logic       mem_ready;
    logic       wpc;
    logic       wir;
    logic       iord;
    logic       wmem;
    logic       wreg;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic [2:0] state;
    logic       retire;
    logic       illegal;

    modport master (
        input  op, func, is_zero, mem_ready,
        output wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, aluc, pcsource, state, retire, illegal
    );

    modport slave (
        output op, func, is_zero, mem_ready,
        input  wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, aluc, pcsource, state, retire, illegal
    );
endinterface

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS control unit sequencing IF/ID/EXE/MEM/WB.
// Ports: clock, reset (async, active-high), bus (mc_cu_if.master) carrying
// IR fields, is_zero, mem_ready in and all datapath controls out.
// MEM_HANDSHAKE=1 makes IF and MEM wait for mem_ready; 0 ignores it.
module mc_cu #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic      clock,
    input  logic      reset,
    mc_cu_if.master   bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic i_shift, i_r_alu, i_imm_alu, legal;
    logic mem_done;
    logic [3:0] alu_op;

    logic wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, sext, shift, alusrca;
    logic retire, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;

    assign r_type    = bus.op == 6'b000000;
    assign i_add     = r_type & (bus.func == 6'b100000);
    assign i_sub     = r_type & (bus.func == 6'b100010);
    assign i_and     = r_type & (bus.func == 6'b100100);
    assign i_or      = r_type & (bus.func == 6'b100101);
    assign i_xor     = r_type & (bus.func == 6'b100110);
    assign i_sll     = r_type & (bus.func == 6'b000000);
    assign i_srl     = r_type & (bus.func == 6'b000010);
    assign i_sra     = r_type & (bus.func == 6'b000011);
    assign i_jr      = r_type & (bus.func == 6'b001000);
    assign i_addi    = bus.op == 6'b001000;
    assign i_andi    = bus.op == 6'b001100;
    assign i_ori     = bus.op == 6'b001101;
    assign i_xori    = bus.op == 6'b001110;
    assign i_lw      = bus.op == 6'b100011;
    assign i_sw      = bus.op == 6'b101011;
    assign i_beq     = bus.op == 6'b000100;
    assign i_bne     = bus.op == 6'b000101;
    assign i_lui     = bus.op == 6'b001111;
    assign i_j       = bus.op == 6'b000010;
    assign i_jal     = bus.op == 6'b000011;
    assign i_shift   = i_sll | i_srl | i_sra;
    assign i_r_alu   = i_add | i_sub | i_and | i_or | i_xor | i_shift;
    assign i_imm_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign legal     = i_r_alu | i_jr | i_imm_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

    // Constant select when the handshake is disabled, so an X on mem_ready never leaks.
    assign mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    assign alu_op = (i_sub | i_beq | i_bne) ? 4'b0100 :
                    (i_and | i_andi)        ? 4'b0001 :
                    (i_or  | i_ori)         ? 4'b0101 :
                    (i_xor | i_xori)        ? 4'b0010 :
                    i_lui                   ? 4'b0110 :
                    i_sll                   ? 4'b0011 :
                    i_srl                   ? 4'b0111 :
                    i_sra                   ? 4'b1111 : 4'b0000;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wpc      = 1'b0;
        wir      = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IF: begin
                alusrcb = 2'b01;
                wir     = mem_done;
                wpc     = mem_done;
                state_d = mem_done ? S_ID : S_IF;
            end
            S_ID: begin
                // Adder computes PC+4 + (imm<<2) here so EXE can branch from it.
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (i_j | i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = i_jal;
                    jal      = i_jal;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (i_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (!legal) begin
                    illegal  = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d  = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                shift   = i_shift;
                alusrcb = (r_type | i_beq | i_bne) ? 2'b00 : 2'b10;
                aluc    = alu_op;
                sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
                if (i_beq | i_bne) begin
                    pcsource = 2'b01;
                    wpc      = (i_beq & bus.is_zero) | (i_bne & ~bus.is_zero);
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d  = (i_lw | i_sw) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                iord    = 1'b1;
                wmem    = i_sw;
                retire  = i_sw & mem_done;
                state_d = !mem_done ? S_MEM : i_sw ? S_IF : S_WB;
            end
            S_WB: begin
                wreg    = 1'b1;
                regrt   = i_imm_alu | i_lw;
                m2reg   = i_lw;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Architectural writes and pulses are suppressed for the whole reset window.
    assign bus.wpc      = wpc & ~reset;
    assign bus.wir      = wir & ~reset;
    assign bus.wmem     = wmem & ~reset;
    assign bus.wreg     = wreg & ~reset;
    assign bus.retire   = retire & ~reset;
    assign bus.illegal  = illegal & ~reset;
    assign bus.iord     = iord;
    assign bus.regrt    = regrt;
    assign bus.m2reg    = m2reg;
    assign bus.jal      = jal;
    assign bus.sext     = sext;
    assign bus.shift    = shift;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.aluc     = aluc;
    assign bus.pcsource = pcsource;
    assign bus.state    = state_q;
endmodule
